seg7_scan: RTL and testbench

SEG7_SCAN -- requirements
Module: seg7_scan

---
 rtl/seg7_scan_pkg.sv | 29 ++
 rtl/seg7_scan_tick.sv | 29 ++
 rtl/seg7_scan.sv | 104 ++++++++++
 tb/tb_seg7_scan.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_pkg.sv
// Shared constants and helpers for the five-digit multiplexed 7-segment scanner.
package seg7_scan_pkg;

  localparam int unsigned NUM_DIG = 5;
  localparam int unsigned SEG_W   = 8;
  localparam int unsigned BUF_W   = NUM_DIG * SEG_W;
  localparam int unsigned IDX_W   = 3;

  localparam logic [SEG_W-1:0] BLANK_PAT = 8'hFF;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIG - 1);

  typedef logic [BUF_W-1:0] seg_buf_t;

  // Lowest bit of the byte belonging to digit i.
  function automatic int unsigned byte_lsb(input int unsigned i);
    return i * SEG_W;
  endfunction

  // Out-of-range indices return zero so the mux never reads past the buffer.
  function automatic logic [SEG_W-1:0] seg_byte(input seg_buf_t b, input logic [IDX_W-1:0] i);
    logic [SEG_W-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < NUM_DIG; k++) begin
      if (i == IDX_W'(k)) r = b[byte_lsb(k) +: SEG_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_tick.sv
// Dwell prescaler: free-running 0..Dwell-1 counter with a terminal-count tick.
module scan_tick #(
  parameter int unsigned Dwell = 50000,
  parameter int unsigned CntW  = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  output logic [CntW-1:0] cnt_o,
  output logic            tick_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CntW'(Dwell - 1));
    cnt_d  = tick_o ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seg7_scan.sv
// Five-digit multiplexed 7-segment driver with shadow/active double buffering
// and frame-synchronous buffer swap.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int unsigned DWELL = 50000,
  parameter int unsigned N_DIG = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_DIG*SEG_W-1:0] s_in,
  input  logic                   load,
  input  logic                   blank,
  output logic [SEG_W-1:0]       seg_n,
  output logic [N_DIG-1:0]       dig_n,
  output logic                   frame_done,
  output logic                   pending
);

  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CntW-1:0]  cnt;
  logic             tick;
  logic             frame_end;
  logic             dig_en;

  logic [IDX_W-1:0] idx_q, idx_d;
  seg_buf_t         shadow_q, shadow_d;
  seg_buf_t         active_q, active_d;
  logic             pending_q, pending_d;
  logic [SEG_W-1:0] seg_n_q, seg_n_d;
  logic [N_DIG-1:0] dig_n_q, dig_n_d;
  logic             frame_done_q, frame_done_d;

  scan_tick #(
    .Dwell (DWELL),
    .CntW  (CntW)
  ) u_scan_tick (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .cnt_o  (cnt),
    .tick_o (tick)
  );

  assign frame_end = tick && (idx_q == LAST_IDX);
  // Count zero is the dark anti-ghost slot at the start of every digit.
  assign dig_en    = (cnt != '0) && !blank;

  always_comb begin
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
  end

  // Transfer reads the old shadow, so a coincident load survives into the next frame.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load) begin
      shadow_d  = s_in;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    seg_n_d      = BLANK_PAT;
    dig_n_d      = '1;
    frame_done_d = frame_end;
    if (dig_en) begin
      seg_n_d = ~seg_byte(active_q, idx_q);
      dig_n_d = ~(N_DIG'(1) << idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      seg_n_q      <= BLANK_PAT;
      dig_n_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      seg_n_q      <= seg_n_d;
      dig_n_q      <= dig_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_n      = seg_n_q;
  assign dig_n      = dig_n_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with DWELL=4, using a cycle-count reference model.
module tb_seg7_scan;

  localparam int unsigned DWELL = 4;
  localparam int unsigned ND    = 5;
  localparam int          FRAME = DWELL * ND;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        load  = 1'b0;
  logic        blank = 1'b0;
  logic [39:0] s_in  = '0;
  logic [7:0]  seg_n;
  logic [4:0]  dig_n;
  logic        frame_done;
  logic        pending;

  always #5 clk = ~clk;

  seg7_scan #(
    .DWELL (DWELL),
    .N_DIG (ND)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_in       (s_in),
    .load       (load),
    .blank      (blank),
    .seg_n      (seg_n),
    .dig_n      (dig_n),
    .frame_done (frame_done),
    .pending    (pending)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: t = cycles since reset release; position within digit and frame follow arithmetically.
  int          t       = 0;
  int          gstep   = 0;
  int          last_fd = -1;
  int          fd_seen = 0;
  logic [39:0] m_shadow = '0;
  logic [39:0] m_active = '0;
  bit          m_pend   = 1'b0;

  typedef struct {
    string       name;
    bit          do_load;
    logic [39:0] data;
    bit          blank;
    int          cycles;
    int          exp_fd;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  task automatic step();
    int          pos;
    int          dig;
    bit          fe;
    bit          en;
    logic [7:0]  e_seg;
    logic [4:0]  e_dig;
    pos   = t % DWELL;
    dig   = (t / DWELL) % ND;
    fe    = (pos == DWELL - 1) && (dig == ND - 1);
    en    = (pos != 0) && !blank;
    e_dig = en ? ~(5'b1 << dig) : 5'h1F;
    e_seg = en ? ~m_active[dig*8 +: 8] : 8'hFF;
    if (fe && m_pend) begin
      m_active = m_shadow;
      m_pend   = 1'b0;
    end
    if (load) begin
      m_shadow = s_in;
      m_pend   = 1'b1;
    end
    t++;
    gstep++;
    @(posedge clk);
    #1;
    chk("seg_n", seg_n, e_seg);
    chk("dig_n", dig_n, e_dig);
    chk("frame_done", frame_done, fe);
    chk("pending", pending, m_pend);
    chk("dig_onehot", ($countones(~dig_n) <= 1), 1);
    if (frame_done) begin
      if (last_fd >= 0) chk("fd_period", gstep - last_fd, FRAME);
      last_fd = gstep;
      fd_seen++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic load_step(input logic [39:0] data);
    s_in = data;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic to_pos(input int p);
    for (int i = 0; i < FRAME && (t % FRAME) != p; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_seg_n", seg_n, 8'hFF);
    chk("rst_dig_n", dig_n, 5'h1F);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_pending", pending, 1'b0);
    t        = 0;
    m_shadow = '0;
    m_active = '0;
    m_pend   = 1'b0;
    last_fd  = -1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Runs one frame and counts lit cycles whose segments match data for the selected digit.
  task automatic count_frame(input logic [39:0] data, output int hits);
    hits = 0;
    repeat (FRAME) begin
      step();
      for (int k = 0; k < ND; k++) begin
        if (dig_n == ~(5'b1 << k) && seg_n == ~data[k*8 +: 8]) hits++;
      end
    end
  endtask

  initial begin
    int c0;
    int c4;
    int hits;
    int fd0;

    vecs[0] = '{"blank_2frames", 1'b0, 40'h0,          1'b1, 2*FRAME, 2};
    vecs[1] = '{"unblank",       1'b0, 40'h0,          1'b0, FRAME,   1};
    vecs[2] = '{"load_c0ffee",   1'b1, 40'hC0FFEE1234, 1'b0, FRAME,   1};
    vecs[3] = '{"show_c0ffee",   1'b0, 40'h0,          1'b0, FRAME,   1};
    vecs[4] = '{"blank_load",    1'b1, 40'h7F3F5B4F66, 1'b1, FRAME,   1};
    vecs[5] = '{"show_after",    1'b0, 40'h0,          1'b0, FRAME,   1};

    #2;
    do_reset();

    // Known pattern: digit 0 and digit 4 each lit 3 of 4 cycles after the first swap.
    load_step(40'h0102040810);
    run(FRAME - 1);
    c0 = 0;
    c4 = 0;
    repeat (FRAME) begin
      step();
      if (dig_n == 5'h1E && seg_n == 8'hEF) c0++;
      if (dig_n == 5'h0F && seg_n == 8'hFE) c4++;
    end
    chk("s1_dig0_cycles", c0, 3);
    chk("s1_dig4_cycles", c4, 3);

    for (int i = 0; i < 6; i++) begin
      blank = vecs[i].blank;
      fd0   = fd_seen;
      if (vecs[i].do_load) begin
        load_step(vecs[i].data);
        run(vecs[i].cycles - 1);
      end else begin
        run(vecs[i].cycles);
      end
      chk({vecs[i].name, "_fd_pulses"}, fd_seen - fd0, vecs[i].exp_fd);
    end
    blank = 1'b0;

    // Last load wins: A is overwritten by B before the frame ends.
    to_pos(0);
    run(5);
    load_step(40'h1111111111);
    run(1);
    load_step(40'h2222222222);
    chk("s2_pending", pending, 1'b1);
    to_pos(0);
    count_frame(40'h1111111111, hits);
    chk("s2_a_hits", hits, 0);
    to_pos(0);
    count_frame(40'h2222222222, hits);
    chk("s2_b_hits", hits, 15);

    // Load coincident with frame end: old shadow swaps in, new one waits a frame.
    to_pos(0);
    run(5);
    load_step(40'h3333333333);
    to_pos(FRAME - 1);
    load_step(40'h4444444444);
    chk("s3_pending", pending, 1'b1);
    count_frame(40'h3333333333, hits);
    chk("s3_old_hits", hits, 15);
    chk("s3_pending_after", pending, 1'b0);
    count_frame(40'h4444444444, hits);
    chk("s3_new_hits", hits, 15);

    // Reset at digit 3 with pending set.
    to_pos(0);
    load_step(40'h5555555555);
    to_pos(13);
    chk("s5_pending_before", pending, 1'b1);
    do_reset();
    count_frame(40'h0, hits);
    chk("s5_dark_hits", hits, 15);

    // Free run with random loads and blanking.
    for (int i = 0; i < 400; i++) begin
      load  = ($urandom % 8) == 0;
      blank = ($urandom % 10) == 0;
      s_in  = {8'($urandom), 32'($urandom)};
      step();
    end
    load  = 1'b0;
    blank = 1'b0;
    run(FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
